mmu_wr_burst_drive: RTL and testbench

MMU_WR_BURST_DRIVE -- requirements
Module: mmu_wr_burst_drive

---
 rtl/mmu_wr_burst_drive_pkg.sv | 25 ++
 rtl/mmu_wr_burst_drive.sv | 130 +++++++++++++
 tb/tb_mmu_wr_burst_drive.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mmu_wr_burst_drive_pkg.sv
// Shared defines (address/data widths, state encodings) and the state type
// for the MMU write-burst driver.
`ifndef MMU_WR_BURST_DRIVE_DEFINES
`define MMU_WR_BURST_DRIVE_DEFINES
`define ADDR_WIDTH 16
`define DATA_DWIDTH 32
`define MMU_WR_ST_IDLE 2'd0
`define MMU_WR_ST_REQ  2'd1
`define MMU_WR_ST_DONE 2'd2
`endif

package mmu_wr_burst_drive_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = `MMU_WR_ST_IDLE,
    ST_REQ  = `MMU_WR_ST_REQ,
    ST_DONE = `MMU_WR_ST_DONE
  } state_t;

  // Beat data carries the 1-based beat number of the beat being presented.
  function automatic logic [`DATA_DWIDTH-1:0] beat_data(input logic [`DATA_DWIDTH-1:0] idx);
    return idx + `DATA_DWIDTH'(2);
  endfunction

endpackage

// File: rtl/mmu_wr_burst_drive.sv
// MMU write-burst driver: issues len beats of (addr, data) on a req/ready bus.
// Optional watchdog abort is built only when MMU_WR_TIMEOUT_EN is defined.
`ifndef MMU_WR_BURST_DRIVE_DEFINES
`define MMU_WR_BURST_DRIVE_DEFINES
`define ADDR_WIDTH 16
`define DATA_DWIDTH 32
`define MMU_WR_ST_IDLE 2'd0
`define MMU_WR_ST_REQ  2'd1
`define MMU_WR_ST_DONE 2'd2
`endif

module mmu_wr_burst_drive
  import mmu_wr_burst_drive_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int LEN_W       = 6
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic [`ADDR_WIDTH-1:0]  i_base_addr,
  input  logic [LEN_W-1:0]        i_burst_len,
  input  logic                    i_mmu_wr_ready,
  output logic                    o_mmu_wr_req,
  output logic [`ADDR_WIDTH-1:0]  o_mmu_wr_addr,
  output logic [`DATA_DWIDTH-1:0] o_mmu_wr_dat,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_timeout
);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] beat_idx;
  logic [LEN_W-1:0] len_q;
  logic             xfer;
  logic             last_beat;
  logic             timeout_hit;

  assign xfer      = o_mmu_wr_req & i_mmu_wr_ready;
  assign last_beat = (beat_idx == (len_q - LEN_W'(1)));

`ifdef MMU_WR_TIMEOUT_EN
  localparam int WCNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [WCNT_W-1:0] wait_cnt;

  // Counts REQ cycles since the last accepted beat; the cycle that would
  // make the count reach TIMEOUT_CYC is the abort cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      wait_cnt <= '0;
    else if (state != ST_REQ || xfer)
      wait_cnt <= '0;
    else
      wait_cnt <= wait_cnt + WCNT_W'(1);
  end

  assign timeout_hit = (state == ST_REQ) && !xfer &&
                       (wait_cnt == WCNT_W'(TIMEOUT_CYC - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign o_timeout = timeout_hit;
  assign o_busy    = (state != ST_IDLE);
  assign o_done    = (state == ST_DONE);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_start)
          state_nxt = (i_burst_len != '0) ? ST_REQ : ST_DONE;
      end
      ST_REQ: begin
        if (timeout_hit)
          state_nxt = ST_IDLE;
        else if (xfer && last_beat)
          state_nxt = ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Bus outputs are registered; they only move on launch, transfer or abort.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_mmu_wr_req  <= 1'b0;
      o_mmu_wr_addr <= '0;
      o_mmu_wr_dat  <= '0;
      beat_idx      <= '0;
      len_q         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (i_start && i_burst_len != '0) begin
            o_mmu_wr_req  <= 1'b1;
            o_mmu_wr_addr <= i_base_addr;
            o_mmu_wr_dat  <= `DATA_DWIDTH'(1);
            beat_idx      <= '0;
            len_q         <= i_burst_len;
          end
        end
        ST_REQ: begin
          if (timeout_hit) begin
            o_mmu_wr_req <= 1'b0;
          end else if (xfer) begin
            if (last_beat) begin
              o_mmu_wr_req <= 1'b0;
            end else begin
              o_mmu_wr_addr <= o_mmu_wr_addr + `ADDR_WIDTH'(1);
              o_mmu_wr_dat  <= beat_data(`DATA_DWIDTH'(beat_idx));
              beat_idx      <= beat_idx + LEN_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmu_wr_burst_drive.sv
// Directed self-checking bench for mmu_wr_burst_drive; the watchdog scenario
// changes with MMU_WR_TIMEOUT_EN.
`ifndef MMU_WR_BURST_DRIVE_DEFINES
`define MMU_WR_BURST_DRIVE_DEFINES
`define ADDR_WIDTH 16
`define DATA_DWIDTH 32
`define MMU_WR_ST_IDLE 2'd0
`define MMU_WR_ST_REQ  2'd1
`define MMU_WR_ST_DONE 2'd2
`endif

module tb_mmu_wr_burst_drive;

  localparam int AW    = `ADDR_WIDTH;
  localparam int DW    = `DATA_DWIDTH;
  localparam int LEN_W = 6;

  logic          i_clk = 1'b0;
  logic          i_rst_n;
  logic          i_start;
  logic [AW-1:0] i_base_addr;
  logic [LEN_W-1:0] i_burst_len;
  logic          i_mmu_wr_ready;
  logic          o_mmu_wr_req;
  logic [AW-1:0] o_mmu_wr_addr;
  logic [DW-1:0] o_mmu_wr_dat;
  logic          o_busy;
  logic          o_done;
  logic          o_timeout;

  int checks   = 0;
  int failures = 0;

  int nbeats, req_cycles, first_req, busy_cycles;
  int done_cnt, done_cycle, to_cnt, to_cycle, hold_err;
  logic [AW-1:0] addr_log [16];
  logic [DW-1:0] dat_log  [16];

  mmu_wr_burst_drive #(.TIMEOUT_CYC(16), .LEN_W(LEN_W)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_start        (i_start),
    .i_base_addr    (i_base_addr),
    .i_burst_len    (i_burst_len),
    .i_mmu_wr_ready (i_mmu_wr_ready),
    .o_mmu_wr_req   (o_mmu_wr_req),
    .o_mmu_wr_addr  (o_mmu_wr_addr),
    .o_mmu_wr_dat   (o_mmu_wr_dat),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_timeout      (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Responder: mode 0 = ready follows req one cycle late, mode 1 = same but
  // only on alternate cycles, otherwise ready tied low.
  task automatic ready_drive_test(input int mode, input logic prev_req, inout logic tog);
    case (mode)
      0:       i_mmu_wr_ready = prev_req;
      1:       begin i_mmu_wr_ready = prev_req & tog; tog = ~tog; end
      default: i_mmu_wr_ready = 1'b0;
    endcase
  endtask

  task automatic run_burst(input logic [AW-1:0] base, input logic [LEN_W-1:0] len,
                           input int mode, input int ncyc);
    logic prev_req, pend, tog;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pdat;
    nbeats = 0; req_cycles = 0; first_req = -1; busy_cycles = 0;
    done_cnt = 0; done_cycle = -1; to_cnt = 0; to_cycle = -1; hold_err = 0;
    prev_req = 1'b0; pend = 1'b0; tog = 1'b0; paddr = '0; pdat = '0;
    i_base_addr = base; i_burst_len = len; i_start = 1'b1; i_mmu_wr_ready = 1'b0;
    step();
    i_start = 1'b0;
    for (int c = 1; c <= ncyc; c++) begin
      ready_drive_test(mode, prev_req, tog);
      if (pend && (o_mmu_wr_req !== 1'b1 || o_mmu_wr_addr !== paddr || o_mmu_wr_dat !== pdat))
        hold_err++;
      if (o_mmu_wr_req === 1'b1) begin
        req_cycles++;
        if (first_req < 0) first_req = c;
      end
      if (o_busy === 1'b1) busy_cycles++;
      if (o_done === 1'b1) begin done_cnt++; done_cycle = c; end
      if (o_timeout === 1'b1) begin to_cnt++; to_cycle = c; end
      if (o_mmu_wr_req === 1'b1 && i_mmu_wr_ready === 1'b1 && nbeats < 16) begin
        addr_log[nbeats] = o_mmu_wr_addr;
        dat_log[nbeats]  = o_mmu_wr_dat;
        nbeats++;
      end
      pend     = (o_mmu_wr_req === 1'b1) && !i_mmu_wr_ready && (o_timeout !== 1'b1);
      paddr    = o_mmu_wr_addr;
      pdat     = o_mmu_wr_dat;
      prev_req = o_mmu_wr_req;
      step();
    end
    i_mmu_wr_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_burst_len = '0; i_mmu_wr_ready = 1'b0;
    step(); step();
    checks++;
    if ({o_mmu_wr_req, o_mmu_wr_addr, o_mmu_wr_dat, o_busy, o_done, o_timeout} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: req=%b addr=%h dat=%h busy=%b done=%b to=%b, all required 0",
               o_mmu_wr_req, o_mmu_wr_addr, o_mmu_wr_dat, o_busy, o_done, o_timeout);
    end
    i_rst_n = 1'b1;
    step();
    checks++;
    if (o_busy !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_idle: busy=%b, required 0", o_busy);
    end
  endtask

  task automatic test_basic_burst();
    run_burst(16'h0010, 6'd4, 0, 10);
    checks++;
    if (nbeats !== 4) begin failures++; $display("[TB] FAIL t1_beats: got %0d, required 4", nbeats); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (addr_log[i] !== AW'(16'h0010 + i) || dat_log[i] !== DW'(i + 1)) begin
        failures++;
        $display("[TB] FAIL t1_beat%0d: got (%h,%0d), required (%h,%0d)",
                 i, addr_log[i], dat_log[i], AW'(16'h0010 + i), i + 1);
      end
    end
    checks++;
    if (req_cycles !== 5 || first_req !== 1) begin
      failures++;
      $display("[TB] FAIL t1_req_cycles: got %0d from cycle %0d, required 5 from cycle 1", req_cycles, first_req);
    end
    checks++;
    if (done_cnt !== 1 || done_cycle !== 6 || busy_cycles !== 6 || to_cnt !== 0) begin
      failures++;
      $display("[TB] FAIL t1_done: done=%0d@%0d busy=%0d to=%0d, required 1@6 busy=6 to=0",
               done_cnt, done_cycle, busy_cycles, to_cnt);
    end
  endtask

  task automatic test_zero_len();
    run_burst(16'h0077, 6'd0, 0, 4);
    checks++;
    if (req_cycles !== 0 || busy_cycles !== 1 || done_cnt !== 1 || done_cycle !== 1) begin
      failures++;
      $display("[TB] FAIL t2_zero_len: req=%0d busy=%0d done=%0d@%0d, required req=0 busy=1 done=1@1",
               req_cycles, busy_cycles, done_cnt, done_cycle);
    end
  endtask

  task automatic test_addr_wrap();
    run_burst(16'hFFFF, 6'd2, 0, 6);
    checks++;
    if (nbeats !== 2 || addr_log[0] !== 16'hFFFF || dat_log[0] !== 32'd1) begin
      failures++;
      $display("[TB] FAIL t3_first_beat: n=%0d (%h,%0d), required n=2 (ffff,1)", nbeats, addr_log[0], dat_log[0]);
    end
    checks++;
    if (addr_log[1] !== 16'h0000 || dat_log[1] !== 32'd2 || done_cnt !== 1) begin
      failures++;
      $display("[TB] FAIL t3_wrap_beat: (%h,%0d) done=%0d, required (0000,2) done=1", addr_log[1], dat_log[1], done_cnt);
    end
  endtask

  task automatic test_ready_stall();
    run_burst(16'h0020, 6'd3, 1, 10);
    checks++;
    if (nbeats !== 3 || hold_err !== 0) begin
      failures++;
      $display("[TB] FAIL t4_stall: beats=%0d hold_errors=%0d, required 3 and 0", nbeats, hold_err);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (addr_log[i] !== AW'(16'h0020 + i) || dat_log[i] !== DW'(i + 1)) begin
        failures++;
        $display("[TB] FAIL t4_beat%0d: got (%h,%0d), required (%h,%0d)",
                 i, addr_log[i], dat_log[i], AW'(16'h0020 + i), i + 1);
      end
    end
    checks++;
    if (done_cnt !== 1 || done_cycle !== 7 || req_cycles !== 6) begin
      failures++;
      $display("[TB] FAIL t4_done: done=%0d@%0d req=%0d, required 1@7 req=6", done_cnt, done_cycle, req_cycles);
    end
  endtask

  task automatic test_timeout();
    run_burst(16'h0030, 6'd3, 2, 24);
`ifdef MMU_WR_TIMEOUT_EN
    checks++;
    if (to_cnt !== 1 || to_cycle !== 16 || req_cycles !== 16) begin
      failures++;
      $display("[TB] FAIL t5_timeout: to=%0d@%0d req=%0d, required 1@16 req=16", to_cnt, to_cycle, req_cycles);
    end
    checks++;
    if (done_cnt !== 0 || nbeats !== 0 || busy_cycles !== 16) begin
      failures++;
      $display("[TB] FAIL t5_abort: done=%0d beats=%0d busy=%0d, required 0 0 16", done_cnt, nbeats, busy_cycles);
    end
`else
    checks++;
    if (to_cnt !== 0 || req_cycles !== 24 || done_cnt !== 0 || hold_err !== 0) begin
      failures++;
      $display("[TB] FAIL t5_wait_forever: to=%0d req=%0d done=%0d hold=%0d, required 0 24 0 0",
               to_cnt, req_cycles, done_cnt, hold_err);
    end
`endif
    i_rst_n = 1'b0;
    step();
    i_rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_burst();
    run_burst(16'h0080, 6'd8, 0, 3);
    checks++;
    if (o_mmu_wr_req !== 1'b1 || o_mmu_wr_addr !== 16'h0082 || o_mmu_wr_dat !== 32'd3) begin
      failures++;
      $display("[TB] FAIL t6_in_flight: req=%b (%h,%0d), required 1 (0082,3)", o_mmu_wr_req, o_mmu_wr_addr, o_mmu_wr_dat);
    end
    i_rst_n = 1'b0;
    #1;
    checks++;
    if ({o_mmu_wr_req, o_mmu_wr_addr, o_mmu_wr_dat, o_busy, o_done, o_timeout} !== '0) begin
      failures++;
      $display("[TB] FAIL t6_async_clear: req=%b addr=%h dat=%h busy=%b done=%b to=%b, all required 0",
               o_mmu_wr_req, o_mmu_wr_addr, o_mmu_wr_dat, o_busy, o_done, o_timeout);
    end
    step(); step();
    checks++;
    if (o_done !== 1'b0 || o_timeout !== 1'b0) begin
      failures++;
      $display("[TB] FAIL t6_no_pulse: done=%b to=%b, required 0 0", o_done, o_timeout);
    end
    i_rst_n = 1'b1;
    run_burst(16'h0040, 6'd1, 0, 6);
    checks++;
    if (first_req !== 1 || nbeats !== 1 || addr_log[0] !== 16'h0040 || dat_log[0] !== 32'd1) begin
      failures++;
      $display("[TB] FAIL t6_new_burst: first_req=%0d beats=%0d (%h,%0d), required 1 1 (0040,1)",
               first_req, nbeats, addr_log[0], dat_log[0]);
    end
    checks++;
    if (done_cnt !== 1 || done_cycle !== 3) begin
      failures++;
      $display("[TB] FAIL t6_new_done: done=%0d@%0d, required 1@3", done_cnt, done_cycle);
    end
  endtask

  initial begin
    test_reset();
    test_basic_burst();
    test_zero_len();
    test_addr_wrap();
    test_ready_stall();
    test_timeout();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
